// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle controller: FSM states, opcodes and datapath mux selects.
// ILLEGAL_TRAP_EN (optional macro) is consumed by the interface and top, not here.
package ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_ADDI = 4'h4;
  localparam logic [3:0] OP_LW   = 4'h5;
  localparam logic [3:0] OP_SW   = 4'h6;
  localparam logic [3:0] OP_BEQ  = 4'h7;
  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_SUB = 2'd1;
  localparam logic [1:0] ALU_AND = 2'd2;
  localparam logic [1:0] ALU_OR  = 2'd3;

  localparam logic [1:0] SRCB_REG = 2'd0;
  localparam logic [1:0] SRCB_IMM = 2'd1;
  localparam logic [1:0] SRCB_ONE = 2'd2;

  localparam logic [1:0] PC_INC    = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath/memory bundle. master = controller, slave = datapath side.
// illegal_op exists only when ILLEGAL_TRAP_EN is defined.
interface multicycle_ctrl_if #(
  parameter int CNT_W = 8
);

  logic [7:0]       instr;
  logic             mem_ready;
  logic             zero;
  logic             mem_req;
  logic             mem_we;
  logic             addr_sel;
  logic             ir_write;
  logic             pc_write;
  logic [1:0]       pc_src;
  logic [1:0]       alu_op;
  logic [1:0]       alu_src_b;
  logic             reg_write;
  logic             mem_to_reg;
  logic             halted;
  logic [CNT_W-1:0] retired;
`ifdef ILLEGAL_TRAP_EN
  logic             illegal_op;
`endif

  modport master (
`ifdef ILLEGAL_TRAP_EN
    output illegal_op,
`endif
    input  instr,
    input  mem_ready,
    input  zero,
    output mem_req,
    output mem_we,
    output addr_sel,
    output ir_write,
    output pc_write,
    output pc_src,
    output alu_op,
    output alu_src_b,
    output reg_write,
    output mem_to_reg,
    output halted,
    output retired
  );

  modport slave (
`ifdef ILLEGAL_TRAP_EN
    input  illegal_op,
`endif
    output instr,
    output mem_ready,
    output zero,
    input  mem_req,
    input  mem_we,
    input  addr_sel,
    input  ir_write,
    input  pc_write,
    input  pc_src,
    input  alu_op,
    input  alu_src_b,
    input  reg_write,
    input  mem_to_reg,
    input  halted,
    input  retired
  );

endinterface

// File: rtl/multicycle_ctrl_opdec.sv
// Combinational opcode classifier feeding the controller FSM from the latched opcode.
module ctrl_opdec
  import ctrl_pkg::*;
#(
  parameter int OP_W = 4
) (
  input  logic [OP_W-1:0] op,
  output logic            is_alu,
  output logic            is_addi,
  output logic            is_lw,
  output logic            is_sw,
  output logic            is_beq,
  output logic            is_jmp,
  output logic            is_halt,
  output logic            is_illegal
);

  // Register-register ALU ops occupy the bottom four codes; 9..E are unassigned.
  always_comb begin
    is_alu     = (op <= OP_OR);
    is_addi    = (op == OP_ADDI);
    is_lw      = (op == OP_LW);
    is_sw      = (op == OP_SW);
    is_beq     = (op == OP_BEQ);
    is_jmp     = (op == OP_JMP);
    is_halt    = (op == OP_HALT);
    is_illegal = (op > OP_JMP) && (op != OP_HALT);
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// FSM controller for the 8-bit multicycle datapath (fetch/decode/exec/mem/wb + halt).
// Optional macro ILLEGAL_TRAP_EN: illegal opcodes trap to HALT and raise sticky illegal_op.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int OP_W  = 4,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  multicycle_ctrl_if.master  bus
);

  state_t           state_q;
  state_t           state_d;
  logic [OP_W-1:0]  op_q;
  logic [CNT_W-1:0] retired_q;
  logic             retire;

  logic is_alu, is_addi, is_lw, is_sw, is_beq, is_jmp, is_halt, is_illegal;

  logic       mem_req_c, mem_we_c, addr_sel_c, ir_write_c, pc_write_c;
  logic [1:0] pc_src_c, alu_op_c, alu_src_b_c;
  logic       reg_write_c, mem_to_reg_c, halted_c;

`ifdef ILLEGAL_TRAP_EN
  logic illegal_q;
  logic set_illegal;
`endif

  ctrl_opdec #(.OP_W(OP_W)) u_opdec (
    .op         (op_q),
    .is_alu     (is_alu),
    .is_addi    (is_addi),
    .is_lw      (is_lw),
    .is_sw      (is_sw),
    .is_beq     (is_beq),
    .is_jmp     (is_jmp),
    .is_halt    (is_halt),
    .is_illegal (is_illegal)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // The opcode is captured on the same edge that loads IR, so EXEC decodes from op_q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q <= '0;
    end else if (state_q == ST_FETCH && bus.mem_ready) begin
      op_q <= bus.instr[7 -: OP_W];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retired_q <= '0;
    end else if (retire) begin
      retired_q <= retired_q + CNT_W'(1);
    end
  end

`ifdef ILLEGAL_TRAP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      illegal_q <= 1'b0;
    end else if (set_illegal) begin
      illegal_q <= 1'b1;
    end
  end
`endif

  // Outputs are held at zero for the whole reset, even though the reset state is FETCH.
  always_comb begin
    state_d      = state_q;
    retire       = 1'b0;
    mem_req_c    = 1'b0;
    mem_we_c     = 1'b0;
    addr_sel_c   = 1'b0;
    ir_write_c   = 1'b0;
    pc_write_c   = 1'b0;
    pc_src_c     = PC_INC;
    alu_op_c     = ALU_ADD;
    alu_src_b_c  = SRCB_REG;
    reg_write_c  = 1'b0;
    mem_to_reg_c = 1'b0;
    halted_c     = 1'b0;
`ifdef ILLEGAL_TRAP_EN
    set_illegal  = 1'b0;
`endif
    if (!rst) begin
      case (state_q)
        ST_FETCH: begin
          mem_req_c = 1'b1;
          if (bus.mem_ready) begin
            ir_write_c  = 1'b1;
            pc_write_c  = 1'b1;
            pc_src_c    = PC_INC;
            alu_src_b_c = SRCB_ONE;
            alu_op_c    = ALU_ADD;
            state_d     = ST_DECODE;
          end
        end
        ST_DECODE: begin
          state_d = ST_EXEC;
        end
        ST_EXEC: begin
          if (is_alu) begin
            alu_op_c    = op_q[1:0];
            alu_src_b_c = SRCB_REG;
            state_d     = ST_WB;
          end else if (is_addi) begin
            alu_src_b_c = SRCB_IMM;
            state_d     = ST_WB;
          end else if (is_lw || is_sw) begin
            alu_src_b_c = SRCB_IMM;
            state_d     = ST_MEM;
          end else if (is_beq) begin
            alu_op_c    = ALU_SUB;
            alu_src_b_c = SRCB_REG;
            pc_src_c    = PC_BRANCH;
            pc_write_c  = bus.zero;
            retire      = 1'b1;
            state_d     = ST_FETCH;
          end else if (is_jmp) begin
            pc_src_c   = PC_JUMP;
            pc_write_c = 1'b1;
            retire     = 1'b1;
            state_d    = ST_FETCH;
          end else if (is_halt) begin
            retire  = 1'b1;
            state_d = ST_HALT;
          end else if (is_illegal) begin
`ifdef ILLEGAL_TRAP_EN
            set_illegal = 1'b1;
            state_d     = ST_HALT;
`else
            retire  = 1'b1;
            state_d = ST_FETCH;
`endif
          end
        end
        ST_MEM: begin
          mem_req_c  = 1'b1;
          addr_sel_c = 1'b1;
          mem_we_c   = is_sw;
          if (bus.mem_ready) begin
            if (is_sw) begin
              retire  = 1'b1;
              state_d = ST_FETCH;
            end else begin
              state_d = ST_WB;
            end
          end
        end
        ST_WB: begin
          reg_write_c  = 1'b1;
          mem_to_reg_c = is_lw;
          retire       = 1'b1;
          state_d      = ST_FETCH;
        end
        ST_HALT: begin
          halted_c = 1'b1;
        end
        default: begin
          state_d = ST_FETCH;
        end
      endcase
    end
  end

  assign bus.mem_req    = mem_req_c;
  assign bus.mem_we     = mem_we_c;
  assign bus.addr_sel   = addr_sel_c;
  assign bus.ir_write   = ir_write_c;
  assign bus.pc_write   = pc_write_c;
  assign bus.pc_src     = pc_src_c;
  assign bus.alu_op     = alu_op_c;
  assign bus.alu_src_b  = alu_src_b_c;
  assign bus.reg_write  = reg_write_c;
  assign bus.mem_to_reg = mem_to_reg_c;
  assign bus.halted     = halted_c;
  assign bus.retired    = retired_q;
`ifdef ILLEGAL_TRAP_EN
  assign bus.illegal_op = illegal_q;
`endif

endmodule
